// File: rtl/bf16_sub_seq_if.sv
// Operand/result handshake bundle for the sequential bf16 subtractor.
// slave = the subtractor, master = operand queue / writeback side.
interface bf16_sub_seq_if #(
    parameter int E = 8,
    parameter int M = 7
);
    logic         valid_i;
    logic         ready_o;
    logic         sa_i;
    logic [E-1:0] ea_i;
    logic [M-1:0] ma_i;
    logic         sb_i;
    logic [E-1:0] eb_i;
    logic [M-1:0] mb_i;
    logic         valid_o;
    logic         ready_i;
    logic         s_o;
    logic [E-1:0] e_o;
    logic [M-1:0] m_o;

    modport slave (
        input  valid_i, sa_i, ea_i, ma_i,
        input  sb_i, eb_i, mb_i, ready_i,
        output ready_o, valid_o, s_o, e_o, m_o
    );

    modport master (
        output valid_i, sa_i, ea_i, ma_i,
        output sb_i, eb_i, mb_i, ready_i,
        input  ready_o, valid_o, s_o, e_o, m_o
    );
endinterface

// File: rtl/bf16_sub_seq.sv
// Multi-cycle bfloat16 subtractor z = a - b, truncating, flush-to-zero.
// Define BF16_SUB_SPECIAL_EN to decode inf/NaN and overflow to inf.
module bf16_sub_seq #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic          clk,
    input  logic          nreset,
    bf16_sub_seq_if.slave io
);
    localparam int W = M + 2;
    localparam int R = M + 3;

    localparam logic [E-1:0] EFE    = {{(E-1){1'b1}}, 1'b0};
    localparam logic [E-1:0] DCLAMP = E'(W);
`ifdef BF16_SUB_SPECIAL_EN
    localparam logic [E-1:0] EMAX  = {E{1'b1}};
    localparam logic [R-1:0] R_ONE = {2'b01, {(M+1){1'b0}}};
    localparam logic [R-1:0] R_NAN = {3'b011, {M{1'b0}}};
`else
    localparam logic [R-1:0] R_SAT = {2'b01, {M{1'b1}}, 1'b0};
`endif

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        OP,
        NORM,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic         sx_q, sx_d;
    logic         sub_q, sub_d;
    logic         spec_q, spec_d;
    logic [E-1:0] ex_q, ex_d;
    logic [E-1:0] d_q, d_d;
    logic [W-1:0] mx_q, mx_d;
    logic [W-1:0] my_q, my_d;
    logic [R-1:0] r_q, r_d;
    logic         vo_q, vo_d;
    logic         so_q, so_d;
    logic [E-1:0] eo_q, eo_d;
    logic [M-1:0] mo_q, mo_d;

    logic         za, zb, sbn, a_ge;
    logic         xs, ys, xz, yz;
    logic [M-1:0] ma, mb, xm, ym;
    logic [E-1:0] xe, ye, d_in, e_dec;
    logic [W-1:0] mx_in, my_in;
    logic [R-1:0] sum;

    // Operand decode: zero forcing, b sign flip, magnitude ordering
    assign za    = (io.ea_i == '0);
    assign zb    = (io.eb_i == '0);
    assign ma    = za ? '0 : io.ma_i;
    assign mb    = zb ? '0 : io.mb_i;
    assign sbn   = ~io.sb_i;
    assign a_ge  = {io.ea_i, ma} >= {io.eb_i, mb};
    assign xs    = a_ge ? io.sa_i : sbn;
    assign ys    = a_ge ? sbn : io.sa_i;
    assign xe    = a_ge ? io.ea_i : io.eb_i;
    assign ye    = a_ge ? io.eb_i : io.ea_i;
    assign xm    = a_ge ? ma : mb;
    assign ym    = a_ge ? mb : ma;
    assign xz    = a_ge ? za : zb;
    assign yz    = a_ge ? zb : za;
    assign mx_in = xz ? '0 : {1'b1, xm, 1'b0};
    assign my_in = yz ? '0 : {1'b1, ym, 1'b0};
    assign d_in  = xe - ye;

    assign sum = sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                       : ({1'b0, mx_q} + {1'b0, my_q});
    assign e_dec = ex_q - E'(1);

`ifdef BF16_SUB_SPECIAL_EN
    logic a_inf, b_inf, a_nan, b_nan;
    logic is_spec, sp_nan;

    assign a_inf   = (io.ea_i == EMAX) && (io.ma_i == '0);
    assign b_inf   = (io.eb_i == EMAX) && (io.mb_i == '0);
    assign a_nan   = (io.ea_i == EMAX) && (io.ma_i != '0);
    assign b_nan   = (io.eb_i == EMAX) && (io.mb_i != '0);
    assign is_spec = a_inf | b_inf | a_nan | b_nan;
    assign sp_nan  = a_nan | b_nan
                   | (a_inf & b_inf & (io.sa_i ^ sbn));
`endif

    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sub_d   = sub_q;
        spec_d  = spec_q;
        ex_d    = ex_q;
        d_d     = d_q;
        mx_d    = mx_q;
        my_d    = my_q;
        r_d     = r_q;
        vo_d    = vo_q;
        so_d    = so_q;
        eo_d    = eo_q;
        mo_d    = mo_q;

        case (state_q)
            IDLE: begin
                if (io.valid_i) begin
                    sx_d    = xs;
                    sub_d   = xs ^ ys;
                    ex_d    = xe;
                    mx_d    = mx_in;
                    my_d    = my_in;
                    d_d     = d_in;
                    spec_d  = 1'b0;
                    state_d = (d_in != '0) ? ALIGN : OP;
`ifdef BF16_SUB_SPECIAL_EN
                    if (is_spec) begin
                        spec_d  = 1'b1;
                        state_d = OP;
                        ex_d    = EMAX;
                        r_d     = R_ONE;
                        if (sp_nan) begin
                            sx_d = 1'b0;
                            r_d  = R_NAN;
                        end
                    end
`endif
                end
            end

            ALIGN: begin
                // Shift distance past the significand: y vanishes at once
                if (d_q >= DCLAMP) begin
                    my_d    = '0;
                    d_d     = '0;
                    state_d = OP;
                end else begin
                    my_d = my_q >> 1;
                    d_d  = d_q - E'(1);
                    if (d_q == E'(1)) begin
                        state_d = OP;
                    end
                end
            end

            OP: begin
                if (spec_q) begin
                    state_d = DONE;
                end else if (sum == '0) begin
                    sx_d    = 1'b0;
                    ex_d    = '0;
                    r_d     = '0;
                    state_d = DONE;
                end else begin
                    r_d = sum;
                    if (sum[R-1] || !sum[R-2]) begin
                        state_d = NORM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            NORM: begin
                if (r_q[R-1]) begin
                    state_d = DONE;
                    if (ex_q >= EFE) begin
`ifdef BF16_SUB_SPECIAL_EN
                        ex_d = EMAX;
                        r_d  = R_ONE;
`else
                        ex_d = EFE;
                        r_d  = R_SAT;
`endif
                    end else begin
                        ex_d = ex_q + E'(1);
                        r_d  = r_q >> 1;
                    end
                end else if (e_dec == '0) begin
                    // Result would be subnormal: flush
                    sx_d    = 1'b0;
                    ex_d    = '0;
                    r_d     = '0;
                    state_d = DONE;
                end else begin
                    ex_d = e_dec;
                    r_d  = {r_q[R-2:0], 1'b0};
                    if (r_q[R-3]) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (!vo_q) begin
                    vo_d = 1'b1;
                    so_d = sx_q;
                    eo_d = ex_q;
                    mo_d = r_q[M:1];
                end else if (io.ready_i) begin
                    vo_d    = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sx_q    <= 1'b0;
            sub_q   <= 1'b0;
            spec_q  <= 1'b0;
            ex_q    <= '0;
            d_q     <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            r_q     <= '0;
            vo_q    <= 1'b0;
            so_q    <= 1'b0;
            eo_q    <= '0;
            mo_q    <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sub_q   <= sub_d;
            spec_q  <= spec_d;
            ex_q    <= ex_d;
            d_q     <= d_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            r_q     <= r_d;
            vo_q    <= vo_d;
            so_q    <= so_d;
            eo_q    <= eo_d;
            mo_q    <= mo_d;
        end
    end

    assign io.ready_o = (state_q == IDLE);
    assign io.valid_o = vo_q;
    assign io.s_o     = so_q;
    assign io.e_o     = eo_q;
    assign io.m_o     = mo_q;
endmodule

// File: tb/tb_bf16_sub_seq.sv
// Bench for bf16_sub_seq: directed vectors, integer reference model,
// per-cycle result compare while valid_o is high.
module tb_bf16_sub_seq;
    logic clk;
    logic nreset;
    int   total;
    int   bad;
    int   exp_lat;

    logic [15:0] expq[$];

    bf16_sub_seq_if #(.E(8), .M(7)) io ();

    bf16_sub_seq #(.E(8), .M(7)) dut (
        .clk    (clk),
        .nreset (nreset),
        .io     (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on 9-bit significands {1,m,g}
    function automatic void model(input logic [15:0] a,
                                  input logic [15:0] b,
                                  output logic [15:0] z,
                                  output int lat);
        int ea, eb, ma, mb, ex, ey, mx, my, d, r, n, dl;
        bit sa, sb, sx, sy;
        sa = a[15];
        sb = !b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = (ea == 0) ? 0 : int'(a[6:0]);
        mb = (eb == 0) ? 0 : int'(b[6:0]);
        if (ea * 128 + ma >= eb * 128 + mb) begin
            sx = sa; ex = ea; mx = (ea == 0) ? 0 : (128 + ma) * 2;
            sy = sb; ey = eb; my = (eb == 0) ? 0 : (128 + mb) * 2;
        end else begin
            sx = sb; ex = eb; mx = (eb == 0) ? 0 : (128 + mb) * 2;
            sy = sa; ey = ea; my = (ea == 0) ? 0 : (128 + ma) * 2;
        end
        d = ex - ey;
        if (d >= 9) begin
            my = 0;
            dl = 1;
        end else begin
            my = my >> d;
            dl = d;
        end
        r = (sx != sy) ? mx - my : mx + my;
        n = 0;
        if (r == 0) begin
            sx = 0;
            ex = 0;
        end else if (r >= 512) begin
            n = 1;
            if (ex + 1 >= 255) begin
                ex = 254;
                r  = 510;
            end else begin
                ex = ex + 1;
                r  = r / 2;
            end
        end else begin
            while (r < 256) begin
                n  = n + 1;
                ex = ex - 1;
                if (ex == 0) begin
                    sx = 0;
                    r  = 0;
                    break;
                end
                r = r * 2;
            end
        end
        z   = {sx, 8'(ex), 7'((r / 2) % 128)};
        lat = 2 + dl + n;
    endfunction

    // Result compare on every cycle valid_o is high; pop on handshake
    always @(negedge clk) begin
        if (nreset && io.valid_o) begin
            if (expq.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("result", {16'd0, io.s_o, io.e_o, io.m_o},
                    {16'd0, expq[0]});
                if (io.ready_i) begin
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] z;
        int lat;
        int k = 0;
        while (!io.ready_o && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", io.ready_o, 1);
        {io.sa_i, io.ea_i, io.ma_i} = a;
        {io.sb_i, io.eb_i, io.mb_i} = b;
        io.valid_i = 1'b1;
        model(a, b, z, lat);
        expq.push_back(z);
        exp_lat = lat;
        @(posedge clk); #1;
        io.valid_i = 1'b0;
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (!io.valid_o && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
    endtask

    task automatic release_out();
        io.ready_i = 1'b1;
        @(posedge clk); #1;
        io.ready_i = 1'b0;
        chk("valid_drop", io.valid_o, 0);
        chk("ready_back", io.ready_o, 1);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b);
        issue(a, b);
        wait_valid();
        release_out();
    endtask

    task automatic pin(input string nm,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] zr,
                       input int lr);
        logic [15:0] z;
        int lat;
        model(a, b, z, lat);
        chk({nm, "_z"}, {16'd0, z}, {16'd0, zr});
        chk({nm, "_lat"}, lat, lr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        exp_lat = 0;
        nreset = 1'b0;
        io.valid_i = 1'b0;
        io.ready_i = 1'b0;
        {io.sa_i, io.ea_i, io.ma_i} = 16'h0;
        {io.sb_i, io.eb_i, io.mb_i} = 16'h0;

        #12;
        chk("rst_valid", io.valid_o, 0);
        chk("rst_out", {io.s_o, io.e_o, io.m_o}, 0);
        #1 nreset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", io.ready_o, 1);
        chk("rst_valid2", io.valid_o, 0);

        // Hand-computed pins for the reference model
        pin("m_2m1",   16'h4000, 16'h3F80, 16'h3F80, 4);
        pin("m_1m1",   16'h3F80, 16'h3F80, 16'h0000, 2);
        pin("m_1pm1",  16'h3F80, 16'hBF80, 16'h4000, 3);
        pin("m_1m15",  16'h3F80, 16'h3FC0, 16'hBF00, 3);
        pin("m_sat",   16'h7F7F, 16'hFF7F, 16'h7F7F, 3);
        pin("m_flush", 16'h0081, 16'h0080, 16'h0000, 3);
        pin("m_neg",   16'hC020, 16'h3F40, 16'hC050, 4);

        run(16'h4000, 16'h3F80);
        run(16'h3F80, 16'h3F80);
        run(16'h3F80, 16'hBF80);
        run(16'h3F80, 16'h3FC0);
        run(16'h3F81, 16'h3F80);
        run(16'h0081, 16'h0080);
        run(16'h7F7F, 16'hFF7F);
        run(16'h3F80, 16'h0000);
        run(16'h3F80, 16'h0055);
        run(16'hC020, 16'h3F40);
        run(16'h3F80, 16'h3B7F);
        run(16'h0000, 16'h0000);
        run(16'h4140, 16'h4100);

        // Result held under backpressure; new operands must be ignored
        issue(16'h4000, 16'h3F80);
        wait_valid();
        {io.sa_i, io.ea_i, io.ma_i} = 16'h4100;
        {io.sb_i, io.eb_i, io.mb_i} = 16'h3F80;
        io.valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", io.ready_o, 0);
            chk("hold_valid", io.valid_o, 1);
        end
        io.valid_i = 1'b0;
        release_out();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ignored_op", io.valid_o, 0);
        end

        // Reset pulse while aligning discards the operation
        issue(16'h4800, 16'h4000);
        #1 nreset = 1'b0;
        #1;
        chk("ar_valid", io.valid_o, 0);
        chk("ar_out", {io.s_o, io.e_o, io.m_o}, 0);
        chk("ar_ready", io.ready_o, 1);
        expq.delete();
        #2 nreset = 1'b1;
        @(posedge clk); #1;
        chk("ar_idle", io.valid_o, 0);
        run(16'h3F80, 16'h3F80);
        run(16'h4000, 16'h3F80);

        @(posedge clk); #1;
        chk("queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
